mem_arbiter: RTL

Two-port arbiter sharing the single RAM port between the instruction fetch stage and the load/store (data) stage. Each requester uses a req/ack handshake; the arbiter grants one access at a time, drives the RAM strobes, waits for RAM completion with a watchdog, and returns read data to the winner. It sits between the pipeline stages and the RAM model.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    state_e            state_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       if_rdata_q;
    logic              if_ack_q;
    logic              if_err_q;
    logic [31:0]       d_rdata_q;
    logic              d_ack_q;
    logic              d_err_q;
    logic [31:0]       mem_addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_wdata_q;
    logic              busy_q;
    logic              grant_data_s;
    logic              timeout_s;

    // Watchdog expires at the end of the TIMEOUT-th ACCESS cycle.
    always_comb begin
        if ((TIMEOUT != 32'd0) && (cnt_q == CNT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_data_q;

    // On a tie, grant whichever port the pointer favours.
    always_comb begin
        if (if_req_i) begin
            grant_data_s = d_req_i & prio_data_q;
        end else begin
            grant_data_s = d_req_i;
        end
    end

    // Pointer moves away from the port just granted.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prio_data_q <= 1'b1;
        end else if ((state_q == IDLE) && (if_req_i || d_req_i)) begin
            prio_data_q <= ~grant_data_s;
        end else begin
            prio_data_q <= prio_data_q;
        end
    end
`else
    // Data requester always wins a tie.
    always_comb begin
        grant_data_s = d_req_i;
    end
`endif

    // Access sequencer with registered RAM strobes and requester responses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= 32'd0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req_i || d_req_i) begin
                        owner_q <= grant_data_s;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                        if (grant_data_s) begin
                            mem_addr_q  <= d_addr_i;
                            mem_read_q  <= ~d_we_i;
                            mem_write_q <= d_we_i;
                            mem_wdata_q <= d_we_i ? d_wdata_i : 32'd0;
                        end else begin
                            mem_addr_q  <= if_addr_i;
                            mem_read_q  <= 1'b1;
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= 32'd0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ready_i || timeout_s) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                        // A write keeps the previous d_rdata even on timeout.
                        if (owner_q) begin
                            d_ack_q <= 1'b1;
                            d_err_q <= ~mem_ready_i;
                            if (!mem_write_q) begin
                                d_rdata_q <= mem_ready_i ? mem_rdata_i : 32'd0;
                            end else begin
                                d_rdata_q <= d_rdata_q;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_err_q   <= ~mem_ready_i;
                            if_rdata_q <= mem_ready_i ? mem_rdata_i : 32'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(32'd1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_err_o    = if_err_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_err_o     = d_err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule
